// File: rtl/cpu.sv
// cpu: 4-bit accumulator core with a TD4-style 12-instruction ISA.
// One instruction per clk_cpu edge; opcode decoded combinationally from inst[7:4],
// all architectural state (pc, A, B, carry, io_out) updated on the rising edge.

// register_file: one 4-bit general register with synchronous reset and load enable.
module register_file (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic       load_i,
   input  logic [3:0] dat_i,
   output logic [3:0] dat_out
);

   logic [3:0] dat_q;
   logic [3:0] dat_d;

   // Next value: load the ALU result when this register is the destination.
   always_comb begin
      dat_d = dat_q;
      if (load_i) dat_d = dat_i;
   end

   // Register storage; reset wins over any load.
   always_ff @(posedge clk_i) begin
      if (reset_i) dat_q <= 4'h0;
      else         dat_q <= dat_d;
   end

   assign dat_out = dat_q;

endmodule

module cpu (
   input  logic       clk_cpu,
   input  logic       reset,
   input  logic [7:0] inst,
   input  logic [3:0] io_in,
   output logic [3:0] pc,
   output logic [3:0] io_out
);

   typedef enum logic [1:0] {
      SRC_A    = 2'd0,
      SRC_B    = 2'd1,
      SRC_IN   = 2'd2,
      SRC_ZERO = 2'd3
   } src_e;

   logic [3:0] opcode;
   logic [3:0] im;
   src_e       src_sel;
   logic       load_a;
   logic       load_b;
   logic       load_out;
   logic       is_jmp;
   logic       is_jnc;

   logic [3:0] src_val;
   logic [4:0] alu_sum;
   logic [3:0] a_val;
   logic [3:0] b_val;

   logic [3:0] pc_q,  pc_d;
   logic       c_q,   c_d;
   logic [3:0] out_q, out_d;

   assign opcode = inst[7:4];
   assign im     = inst[3:0];

   // Decode: pick the ALU source and the single destination for this opcode.
   // Undefined opcodes fall through to a NOP with a zero source, so carry clears.
   always_comb begin
      src_sel  = SRC_ZERO;
      load_a   = 1'b0;
      load_b   = 1'b0;
      load_out = 1'b0;
      is_jmp   = 1'b0;
      is_jnc   = 1'b0;
      unique case (opcode)
         4'b0000: begin src_sel = SRC_A;    load_a   = 1'b1; end // ADD A,Im
         4'b0101: begin src_sel = SRC_B;    load_b   = 1'b1; end // ADD B,Im
         4'b0011: begin src_sel = SRC_ZERO; load_a   = 1'b1; end // MOV A,Im
         4'b0111: begin src_sel = SRC_ZERO; load_b   = 1'b1; end // MOV B,Im
         4'b0001: begin src_sel = SRC_B;    load_a   = 1'b1; end // MOV A,B
         4'b0100: begin src_sel = SRC_A;    load_b   = 1'b1; end // MOV B,A
         4'b0010: begin src_sel = SRC_IN;   load_a   = 1'b1; end // IN A
         4'b0110: begin src_sel = SRC_IN;   load_b   = 1'b1; end // IN B
         4'b1001: begin src_sel = SRC_B;    load_out = 1'b1; end // OUT B
         4'b1011: begin src_sel = SRC_ZERO; load_out = 1'b1; end // OUT Im
         4'b1111: begin src_sel = SRC_ZERO; is_jmp   = 1'b1; end // JMP Im
         4'b1110: begin src_sel = SRC_ZERO; is_jnc   = 1'b1; end // JNC Im
         default: begin src_sel = SRC_ZERO;                  end // NOP
      endcase
   end

   // ALU: source + Im, bit 4 is the carry-out that feeds the carry flag.
   always_comb begin
      src_val = 4'h0;
      case (src_sel)
         SRC_A:    src_val = a_val;
         SRC_B:    src_val = b_val;
         SRC_IN:   src_val = io_in;
         default:  src_val = 4'h0;
      endcase
      alu_sum = {1'b0, src_val} + {1'b0, im};
   end

   register_file register_file_a (
      .clk_i   (clk_cpu),
      .reset_i (reset),
      .load_i  (load_a),
      .dat_i   (alu_sum[3:0]),
      .dat_out (a_val)
   );

   register_file register_file_b (
      .clk_i   (clk_cpu),
      .reset_i (reset),
      .load_i  (load_b),
      .dat_i   (alu_sum[3:0]),
      .dat_out (b_val)
   );

   // Next state for pc, carry and output port. JNC looks at the carry left by
   // the previous instruction (c_q), not the one this instruction produces.
   always_comb begin
      c_d   = alu_sum[4];
      out_d = load_out ? alu_sum[3:0] : out_q;
      if (is_jmp || (is_jnc && !c_q)) pc_d = im;
      else                            pc_d = pc_q + 4'd1;
   end

   // Architectural state update; reset discards the instruction in flight.
   always_ff @(posedge clk_cpu) begin
      if (reset) begin
         pc_q  <= 4'h0;
         c_q   <= 1'b0;
         out_q <= 4'h0;
      end else begin
         pc_q  <= pc_d;
         c_q   <= c_d;
         out_q <= out_d;
      end
   end

   assign pc     = pc_q;
   assign io_out = out_q;

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed program vectors for the cpu core. Each driven instruction
// pushes the expected {pc, A, B, io_out} after its edge; a monitor pops and
// compares one entry per clock, #1 after the rising edge.
module tb_cpu;

   localparam int W = 16;

   logic       clk_cpu;
   logic       reset;
   logic [7:0] inst;
   logic [3:0] io_in;
   logic [3:0] pc;
   logic [3:0] io_out;

   logic [W-1:0] exp_q[$];
   int           n_checks;
   int           n_errors;
   int           step_no;
   bit           drive_done;

   cpu dut (
      .clk_cpu (clk_cpu),
      .reset   (reset),
      .inst    (inst),
      .io_in   (io_in),
      .pc      (pc),
      .io_out  (io_out)
   );

   // clock / reset defaults
   initial begin
      clk_cpu = 1'b0;
      forever #5 clk_cpu = ~clk_cpu;
   end

   // driver: apply one instruction for the next edge and record what should follow it
   task automatic step(input logic rst, input logic [7:0] ins, input logic [3:0] din,
                       input logic [3:0] e_pc, input logic [3:0] e_a,
                       input logic [3:0] e_b, input logic [3:0] e_out);
      reset = rst;
      inst  = ins;
      io_in = din;
      exp_q.push_back({e_pc, e_a, e_b, e_out});
      @(negedge clk_cpu);
   endtask

   // monitor / scoreboard
   initial begin
      logic [W-1:0] exp_v;
      logic [W-1:0] act_v;
      step_no = 0;
      forever begin
         @(posedge clk_cpu);
         #1;
         if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {pc, dut.register_file_a.dat_out, dut.register_file_b.dat_out, io_out};
            n_checks++;
            if (act_v !== exp_v) begin
               n_errors++;
               $display("FAIL step%0d {pc,a,b,out}: got %h want %h", step_no, act_v, exp_v);
            end
            step_no++;
         end
      end
   end

   // stimulus
   initial begin
      int wait_cycles;
      n_checks   = 0;
      n_errors   = 0;
      drive_done = 1'b0;
      reset = 1'b1; inst = 8'h00; io_in = 4'h0;

      // reset held 5 cycles with arbitrary instructions
      for (int i = 0; i < 5; i++)
         step(1'b1, 8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 4'h0, 4'h0, 4'h0, 4'h0);

      // NOP stream: pc counts up and wraps F -> 0
      for (int i = 1; i <= 17; i++)
         step(1'b0, 8'h80, 4'h0, 4'(i), 4'h0, 4'h0, 4'h0);

      step(1'b1, 8'h80, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

      //      rst   inst   io     pc     a      b      out
      step(1'b0, 8'h33, 4'h0, 4'h1, 4'h3, 4'h0, 4'h0); // MOV A,3
      step(1'b0, 8'h05, 4'h0, 4'h2, 4'h8, 4'h0, 4'h0); // ADD A,5
      step(1'b0, 8'h40, 4'h0, 4'h3, 4'h8, 4'h8, 4'h0); // MOV B,A
      step(1'b0, 8'h90, 4'h0, 4'h4, 4'h8, 4'h8, 4'h8); // OUT B
      step(1'b0, 8'h3F, 4'h0, 4'h5, 4'hF, 4'h8, 4'h8); // MOV A,F
      step(1'b0, 8'h02, 4'h0, 4'h6, 4'h1, 4'h8, 4'h8); // ADD A,2 -> C=1
      step(1'b0, 8'hE9, 4'h0, 4'h7, 4'h1, 4'h8, 4'h8); // JNC 9 not taken, C cleared
      step(1'b0, 8'hE9, 4'h0, 4'h9, 4'h1, 4'h8, 4'h8); // JNC 9 taken
      step(1'b0, 8'hF7, 4'h0, 4'h7, 4'h1, 4'h8, 4'h8); // JMP 7
      step(1'b0, 8'hBA, 4'h0, 4'h8, 4'h1, 4'h8, 4'hA); // OUT A (immediate)
      step(1'b0, 8'h20, 4'h6, 4'h9, 4'h6, 4'h8, 4'hA); // IN A
      step(1'b0, 8'h60, 4'h6, 4'hA, 4'h6, 4'h6, 4'hA); // IN B
      step(1'b0, 8'h7C, 4'h6, 4'hB, 4'h6, 4'hC, 4'hA); // MOV B,C
      step(1'b0, 8'h10, 4'h6, 4'hC, 4'hC, 4'hC, 4'hA); // MOV A,B
      step(1'b0, 8'h55, 4'h6, 4'hD, 4'hC, 4'h1, 4'hA); // ADD B,5 overflow -> C=1
      step(1'b0, 8'hE0, 4'h6, 4'hE, 4'hC, 4'h1, 4'hA); // JNC 0 not taken
      step(1'b0, 8'h2A, 4'h6, 4'hF, 4'h0, 4'h1, 4'hA); // IN A +A overflow -> C=1
      step(1'b0, 8'hE3, 4'h6, 4'h0, 4'h0, 4'h1, 4'hA); // JNC not taken, pc wraps
      step(1'b0, 8'hE3, 4'h6, 4'h3, 4'h0, 4'h1, 4'hA); // JNC taken
      step(1'b0, 8'h93, 4'h6, 4'h4, 4'h0, 4'h1, 4'h4); // OUT B+3
      step(1'b0, 8'hCF, 4'h6, 4'h5, 4'h0, 4'h1, 4'h4); // undefined -> NOP
      step(1'b0, 8'h0F, 4'h6, 4'h6, 4'hF, 4'h1, 4'h4); // ADD A,F no carry
      step(1'b0, 8'hE2, 4'h6, 4'h2, 4'hF, 4'h1, 4'h4); // JNC 2 taken
      step(1'b0, 8'h35, 4'h6, 4'h3, 4'h5, 4'h1, 4'h4); // MOV A,5
      step(1'b0, 8'hB9, 4'h6, 4'h4, 4'h5, 4'h1, 4'h9); // OUT 9
      step(1'b1, 8'h3F, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0); // reset mid-program
      step(1'b0, 8'h33, 4'h6, 4'h1, 4'h3, 4'h0, 4'h0); // resume at 0: MOV A,3
      drive_done = 1'b1;

      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(negedge clk_cpu);
         wait_cycles++;
      end
      if (exp_q.size() != 0) begin
         n_checks++;
         n_errors++;
         $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
